meter_session_ctrl: RTL and testbench
=====================================

Name: meter_session_ctrl

Overview:
- Session sequencer for the parking meter. Qualifies the raw occupancy signal from the sensor and walks each parking session through arrival, free grace, billing, departure and final-cost hold.
- Drives the clear and increment of the second counter, and selects what the display shows (time vs cost, blink).
- Sits between the sensor, the 1 Hz clock domain output, the second counter and the display mux.

Parameters:
- ARRIVE_SEC, 3, consecutive occupied ticks needed to confirm arrival
- DEPART_SEC, 3, consecutive vacant ticks needed to confirm departure
- GRACE_SEC, 10, free seconds after confirmed arrival before billing starts
- HOLD_SEC, 15, seconds the final cost is held after departure
- SEC_W, 12, width of the second count
- MAX_SEC, 3599, saturation value of billed seconds (59:59)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick_1hz  in  1  single-cycle enable pulse in the clk domain, once per second
- parked_raw  in  1  unqualified occupancy from the sensor
- sec_count  in  SEC_W  current value of the second counter
- count_clr  out  1  synchronous clear request to the second counter
- count_inc  out  1  one-cycle increment strobe to the second counter
- show_cost  out  1  1 = display cost digits, 0 = display time digits
- blink  out  1  display blink enable
- capped  out  1  billed time has saturated at MAX_SEC
- state  out  3  current FSM state, for debug and LEDs
- session_done  out  1  one-cycle pulse on entry to HOLD

Behaviour:
- Reset (rst=0, async): state=IDLE, qualification and interval timers=0, count_clr=1, count_inc=0, show_cost=0, blink=0, capped=0, session_done=0.
- All state and timer updates happen on the rising clk edge and only in cycles where tick_1hz=1. parked_raw is sampled only in those cycles.
- Outputs are Moore decodes of the state register. The exceptions are count_inc = tick_1hz & (state==BILLING) & (sec_count<MAX_SEC), and capped = (state==BILLING or later in the same session) & (sec_count==MAX_SEC).
- IDLE: count_clr=1. Tick with parked_raw=1 -> ARRIVING, q=1.
- ARRIVING: count_clr=1.
  - Tick with parked_raw=0 -> IDLE.
  - Tick with parked_raw=1 -> q+1; when the count reaches ARRIVE_SEC -> GRACE with t=0.
  - If ARRIVE_SEC=1, the IDLE tick goes straight to GRACE.
- GRACE: count_clr=1, show_cost=0.
  - Tick with parked_raw=0 -> IDLE (free session; no HOLD, no session_done).
  - Otherwise t+1; at t==GRACE_SEC -> BILLING.
- BILLING: count_clr=0, show_cost=1. count_inc fires on each tick. The counter saturates: no count_inc at MAX_SEC.
  - Tick with parked_raw=0 -> DEPARTING, q=1. The count_inc on that same tick still fires.
- DEPARTING: count frozen (count_inc=0), show_cost=1.
  - Tick with parked_raw=1 -> BILLING. The vacant seconds are not billed.
  - Tick with parked_raw=0 -> q+1; at DEPART_SEC -> HOLD with t=0; pulse session_done for that one cycle.
- HOLD: show_cost=1, blink=1, count frozen, capped retained.
  - Tick with parked_raw=1 -> ARRIVING, q=1. This preempts the hold; count_clr is reasserted from the next cycle.
  - Otherwise t+1; at t==HOLD_SEC -> IDLE.
- Reset mid-session returns to IDLE immediately and clears all timers. The second counter is cleared through count_clr=1.
- tick_1hz held high for more than 1 cycle is illegal. The behaviour is undefined, and an assertion flags it.
- Timers are ceil(log2(max(ARRIVE_SEC, DEPART_SEC, GRACE_SEC, HOLD_SEC)+1)) bits wide and never wrap; a parameter value of 0 is illegal.
- Unused state encodings -> IDLE on the next clk edge.

Decomposition:
- Shared package meter_pkg: the state enum (IDLE=0, ARRIVING=1, GRACE=2, BILLING=3, DEPARTING=4, HOLD=5), SEC_W, and MAX_SEC.
- One sub-module, tick_timer: a tick-gated up-counter with sync clear and terminal-count compare. It is instantiated twice: qualification timer q and interval timer t.

Test Plan:
- Reset mid-BILLING with sec_count=42 -> state=IDLE asynchronously, count_clr=1 and show_cost=0 in the same cycle, counter reads 0 after the next edge.
- parked_raw=1 for 2 ticks then 0 -> ARRIVING then IDLE, count_inc never asserted.
- Arrive (3 ticks) + 10 grace ticks + 20 occupied ticks -> exactly 20 count_inc pulses, sec_count=20, show_cost=1.
- In BILLING: vacant 2 ticks, occupied, then vacant 3 ticks -> BILLING re-entered after the 2-tick gap, HOLD reached after 3; session_done pulses once; sec_count frozen (the first vacant tick of each run still increments, so sec_count=22 with the 20-tick setup, since the gap is not billed).
- HOLD for 15 ticks -> blink=1 throughout, IDLE on the 15th tick, count_clr=1. Separately, parked_raw=1 on HOLD tick 5 -> ARRIVING.
- Preload sec_count=3598 in BILLING, 3 ticks -> one count_inc, sec_count=3599, capped=1, no further strobes.

Source files
------------

// File: rtl/meter_pkg.sv
// Shared types and constants for the parking meter session logic.
// Also holds the display decode used by the session controller.
package meter_pkg;

  localparam int SEC_W   = 12;
  localparam int MAX_SEC = 3599;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARRIVING  = 3'd1,
    GRACE     = 3'd2,
    BILLING   = 3'd3,
    DEPARTING = 3'd4,
    HOLD      = 3'd5
  } state_t;

  typedef struct packed {
    logic count_clr;
    logic show_cost;
    logic blink;
  } disp_t;

  function automatic disp_t decode(input state_t s);
    disp_t d;
    d.count_clr = (s == IDLE) || (s == ARRIVING) || (s == GRACE);
    d.show_cost = (s == BILLING) || (s == DEPARTING) || (s == HOLD);
    d.blink     = (s == HOLD);
    return d;
  endfunction

  // Timers must hold the largest interval value without wrapping.
  function automatic int timer_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/meter_session_ctrl_if.sv
// Signal bundle between the session controller and its neighbours
// (sensor, 1 Hz tick, second counter, display mux).
interface meter_session_ctrl_if #(parameter int SEC_W = meter_pkg::SEC_W);

  logic             tick_1hz;
  logic             parked_raw;
  logic [SEC_W-1:0] sec_count;
  logic             count_clr;
  logic             count_inc;
  logic             show_cost;
  logic             blink;
  logic             capped;
  logic [2:0]       state;
  logic             session_done;

  modport master (
    output tick_1hz, parked_raw, sec_count,
    input  count_clr, count_inc, show_cost, blink, capped, state, session_done
  );

  modport slave (
    input  tick_1hz, parked_raw, sec_count,
    output count_clr, count_inc, show_cost, blink, capped, state, session_done
  );

endinterface

// File: rtl/tick_timer.sv
// Tick-gated up-counter with sync clear and a terminal-count look-ahead.
// clr and inc together restart the count at 1.
module tick_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] term,
  output logic         reach
);

  logic [W-1:0] count;

  // reach says the increment taken on this tick lands on the terminal value.
  assign reach = (({1'b0, count} + (W+1)'(1)) == {1'b0, term});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      if (clr)
        count <= inc ? W'(1) : '0;
      else if (inc && (count != '1))
        count <= count + W'(1);
    end
  end

endmodule

// File: rtl/meter_session_ctrl.sv
// Parking session sequencer: qualifies occupancy and steps each session
// through arrival, grace, billing, departure and final-cost hold.
module meter_session_ctrl #(
  parameter int ARRIVE_SEC = 3,
  parameter int DEPART_SEC = 3,
  parameter int GRACE_SEC  = 10,
  parameter int HOLD_SEC   = 15,
  parameter int SEC_W      = meter_pkg::SEC_W,
  parameter int MAX_SEC    = meter_pkg::MAX_SEC
) (
  input logic                 clk,
  input logic                 rst_n,
  meter_session_ctrl_if.slave bus
);

  import meter_pkg::*;

  localparam int TW = timer_width(ARRIVE_SEC, DEPART_SEC, GRACE_SEC, HOLD_SEC);

  state_t        state;
  state_t        state_nxt;
  disp_t         disp;
  logic          session_done_r;
  logic          parked;
  logic          q_clr, q_inc, q_reach;
  logic          t_clr, t_inc, t_reach;
  logic [TW-1:0] q_term, t_term;

  assign parked = bus.parked_raw;

  // q counts consecutive occupied/vacant ticks; t counts grace and hold seconds.
  always_comb begin
    q_clr = 1'b1;
    q_inc = 1'b0;
    t_clr = 1'b1;
    t_inc = 1'b0;
    case (state)
      IDLE:      q_inc = parked;
      ARRIVING:  begin q_clr = ~parked; q_inc = parked; end
      GRACE:     begin t_clr = ~parked; t_inc = parked; end
      BILLING:   q_inc = ~parked;
      DEPARTING: begin q_clr = parked; q_inc = ~parked; end
      HOLD:      begin q_inc = parked; t_clr = parked; t_inc = ~parked; end
      default:   ;
    endcase
  end

  assign q_term = (state == DEPARTING) ? TW'(DEPART_SEC) : TW'(ARRIVE_SEC);
  assign t_term = (state == HOLD)      ? TW'(HOLD_SEC)   : TW'(GRACE_SEC);

  tick_timer #(.W(TW)) u_q_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (bus.tick_1hz),
    .clr   (q_clr),
    .inc   (q_inc),
    .term  (q_term),
    .reach (q_reach)
  );

  tick_timer #(.W(TW)) u_t_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (bus.tick_1hz),
    .clr   (t_clr),
    .inc   (t_inc),
    .term  (t_term),
    .reach (t_reach)
  );

  function automatic state_t next_state(input state_t s, input logic p,
                                        input logic qr, input logic tr);
    case (s)
      IDLE:      return p ? ((ARRIVE_SEC == 1) ? GRACE : ARRIVING) : IDLE;
      ARRIVING:  return !p ? IDLE : (qr ? GRACE : ARRIVING);
      GRACE:     return !p ? IDLE : (tr ? BILLING : GRACE);
      BILLING:   return p ? BILLING : ((DEPART_SEC == 1) ? HOLD : DEPARTING);
      DEPARTING: return p ? BILLING : (qr ? HOLD : DEPARTING);
      HOLD:      return p ? ((ARRIVE_SEC == 1) ? GRACE : ARRIVING) : (tr ? IDLE : HOLD);
      default:   return IDLE;
    endcase
  endfunction

  assign state_nxt = next_state(state, parked, q_reach, t_reach);

  // Display controls are registered from the next state so they change with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      disp           <= decode(IDLE);
      session_done_r <= 1'b0;
    end else begin
      session_done_r <= 1'b0;
      if (bus.tick_1hz || !(state inside {IDLE, ARRIVING, GRACE, BILLING, DEPARTING, HOLD})) begin
        state          <= state_nxt;
        disp           <= decode(state_nxt);
        session_done_r <= (state_nxt == HOLD) && (state != HOLD);
      end
    end
  end

  assign bus.state        = state;
  assign bus.count_clr    = disp.count_clr;
  assign bus.show_cost    = disp.show_cost;
  assign bus.blink        = disp.blink;
  assign bus.session_done = session_done_r;
  assign bus.count_inc    = bus.tick_1hz && (state == BILLING) &&
                            (bus.sec_count < SEC_W'(MAX_SEC));
  assign bus.capped       = (state inside {BILLING, DEPARTING, HOLD}) &&
                            (bus.sec_count == SEC_W'(MAX_SEC));

  tick_single_a: assert property (@(posedge clk) disable iff (!rst_n)
                                  bus.tick_1hz |=> !bus.tick_1hz);

endmodule

// File: tb/tb_meter_session_ctrl.sv
// Bench for meter_session_ctrl: models the second counter and checks every
// tick against a run-length model of the session rules.
module tb_meter_session_ctrl;

  localparam int ARR  = 3;
  localparam int DEP  = 3;
  localparam int GRC  = 10;
  localparam int HLD  = 15;
  localparam int MAXS = 3599;

  localparam int S_IDLE  = 0;
  localparam int S_ARR   = 1;
  localparam int S_GRACE = 2;
  localparam int S_BILL  = 3;
  localparam int S_DEP   = 4;
  localparam int S_HOLD  = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        preload_en = 1'b0;
  logic [11:0] preload_val = '0;

  int checks = 0;
  int failures = 0;
  int inc_count = 0;
  int done_count = 0;

  int m_state = S_IDLE;
  int occ_run = 0;
  int vac_run = 0;
  int elapsed = 0;
  int m_sec = 0;

  always #5 clk = ~clk;

  meter_session_ctrl_if bus ();

  meter_session_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Second counter as it sits next to the controller, with a test preload.
  always @(posedge clk) begin
    if (preload_en)
      bus.sec_count <= preload_val;
    else if (bus.count_clr)
      bus.sec_count <= '0;
    else if (bus.count_inc)
      bus.sec_count <= bus.sec_count + 12'd1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic modelTick(input bit p, output bit done);
    int  prev;
    bit  inc;
    prev = m_state;
    inc  = (m_state == S_BILL) && (m_sec < MAXS);
    done = 1'b0;
    case (m_state)
      S_IDLE, S_HOLD: begin
        if (p) begin
          occ_run = 1;
          elapsed = 0;
          m_state = (occ_run == ARR) ? S_GRACE : S_ARR;
        end else if (m_state == S_HOLD) begin
          elapsed++;
          if (elapsed == HLD) m_state = S_IDLE;
        end
      end
      S_ARR: begin
        if (!p) m_state = S_IDLE;
        else begin
          occ_run++;
          if (occ_run == ARR) begin m_state = S_GRACE; elapsed = 0; end
        end
      end
      S_GRACE: begin
        if (!p) m_state = S_IDLE;
        else begin
          elapsed++;
          if (elapsed == GRC) m_state = S_BILL;
        end
      end
      S_BILL: begin
        if (!p) begin
          vac_run = 1;
          if (vac_run == DEP) begin m_state = S_HOLD; elapsed = 0; done = 1'b1; end
          else m_state = S_DEP;
        end
      end
      default: begin
        if (p) m_state = S_BILL;
        else begin
          vac_run++;
          if (vac_run == DEP) begin m_state = S_HOLD; elapsed = 0; done = 1'b1; end
        end
      end
    endcase
    if (prev <= S_GRACE) m_sec = 0;
    else if (inc) m_sec++;
  endtask

  task automatic checkState(input bit exp_done);
    checkOutput("state", bus.state, m_state);
    checkOutput("count_clr", bus.count_clr, m_state <= S_GRACE);
    checkOutput("show_cost", bus.show_cost, m_state >= S_BILL);
    checkOutput("blink", bus.blink, m_state == S_HOLD);
    checkOutput("capped", bus.capped, (m_state >= S_BILL) && (m_sec == MAXS));
    checkOutput("session_done", bus.session_done, exp_done);
    checkOutput("sec_count", bus.sec_count, m_sec);
  endtask

  // One 1 Hz tick followed by a short random gap; called at posedge+1.
  task automatic applyStimulus(input bit p);
    bit exp_done;
    int gap;
    bus.tick_1hz   = 1'b1;
    bus.parked_raw = p;
    #1;
    checkOutput("count_inc", bus.count_inc, (m_state == S_BILL) && (m_sec < MAXS));
    if (bus.count_inc) inc_count++;
    @(posedge clk); #1;
    bus.tick_1hz   = 1'b0;
    bus.parked_raw = 1'($urandom_range(0, 1));
    modelTick(p, exp_done);
    checkState(exp_done);
    if (bus.session_done) done_count++;
    gap = $urandom_range(1, 3);
    repeat (gap) begin @(posedge clk); #1; end
    if (m_state <= S_GRACE) m_sec = 0;
    checkOutput("done_gap", bus.session_done, 0);
    checkOutput("sec_gap", bus.sec_count, m_sec);
    checkOutput("count_inc_gap", bus.count_inc, 0);
  endtask

  task automatic applyPreload(input int value);
    preload_val = 12'(value);
    preload_en  = 1'b1;
    @(posedge clk); #1;
    preload_en  = 1'b0;
    m_sec       = value;
  endtask

  task automatic modelReset();
    m_state = S_IDLE;
    occ_run = 0;
    vac_run = 0;
    elapsed = 0;
  endtask

  initial begin
    bus.tick_1hz   = 1'b0;
    bus.parked_raw = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_state", bus.state, S_IDLE);
    checkOutput("rst_count_clr", bus.count_clr, 1);
    checkOutput("rst_count_inc", bus.count_inc, 0);
    checkOutput("rst_show_cost", bus.show_cost, 0);
    checkOutput("rst_blink", bus.blink, 0);
    checkOutput("rst_capped", bus.capped, 0);
    checkOutput("rst_done", bus.session_done, 0);
    checkOutput("rst_sec", bus.sec_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Short occupancy blip never confirms arrival.
    inc_count = 0;
    applyStimulus(1'b1);
    checkOutput("blip_arriving", bus.state, S_ARR);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("blip_idle", bus.state, S_IDLE);
    checkOutput("blip_no_inc", inc_count, 0);

    // Arrival, grace, then 20 billed seconds.
    inc_count = 0;
    repeat (33) applyStimulus(1'b1);
    checkOutput("bill20_state", bus.state, S_BILL);
    checkOutput("bill20_incs", inc_count, 20);
    checkOutput("bill20_sec", bus.sec_count, 20);
    checkOutput("bill20_cost", bus.show_cost, 1);

    // Short vacancy gap is not billed; the second vacancy run ends the session.
    done_count = 0;
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("gap_rebill", bus.state, S_BILL);
    repeat (3) applyStimulus(1'b0);
    checkOutput("depart_hold", bus.state, S_HOLD);
    checkOutput("depart_sec", bus.sec_count, 22);
    checkOutput("depart_done_pulses", done_count, 1);

    // Full hold then back to idle.
    repeat (14) applyStimulus(1'b0);
    checkOutput("hold_blink", bus.blink, 1);
    applyStimulus(1'b0);
    checkOutput("hold_expire", bus.state, S_IDLE);
    checkOutput("hold_expire_clr", bus.count_clr, 1);

    // New arrival preempts the hold on its 5th tick.
    repeat (33) applyStimulus(1'b1);
    repeat (3) applyStimulus(1'b0);
    repeat (4) applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkOutput("preempt_arriving", bus.state, S_ARR);
    checkOutput("preempt_sec", bus.sec_count, 0);

    // Saturation at 59:59.
    repeat (12) applyStimulus(1'b1);
    checkOutput("cap_billing", bus.state, S_BILL);
    applyPreload(3598);
    inc_count = 0;
    repeat (3) applyStimulus(1'b1);
    checkOutput("cap_incs", inc_count, 1);
    checkOutput("cap_sec", bus.sec_count, MAXS);
    checkOutput("cap_flag", bus.capped, 1);

    // Asynchronous reset in the middle of billing.
    applyPreload(42);
    checkOutput("mid_sec42", bus.sec_count, 42);
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("mid_rst_state", bus.state, S_IDLE);
    checkOutput("mid_rst_clr", bus.count_clr, 1);
    checkOutput("mid_rst_cost", bus.show_cost, 0);
    @(posedge clk); #1;
    m_sec = 0;
    checkOutput("mid_rst_sec", bus.sec_count, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Random occupancy runs with occasional near-cap preloads.
    repeat (300) begin
      bit p;
      int len;
      p   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 6);
      if ((m_state == S_BILL) && ($urandom_range(0, 9) == 0))
        applyPreload($urandom_range(3590, 3599));
      repeat (len) applyStimulus(p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
